// File: rtl/meta_route_fanout.sv
// meta_route_fanout: steers each input beat to one of NUM_OUT first-word-fall-through
// FIFOs using a destination field carried in the beat. Beats with an out-of-range
// destination are accepted and dropped.
// Optional feature macro: META_ROUTE_FANOUT_STATS_EN builds the accept/drop/pop
// counters and the stats_out adder. When it is undefined, the stats outputs are tied to 0.
module meta_route_fanout #(
  parameter int DATA_BITS = 256,
  parameter int NUM_OUT   = 4,
  parameter int DEPTH     = 8,
  parameter int AF_THRESH = DEPTH - 2,
  parameter int DEST_LSB  = 0
) (
  input  logic                          Clk,
  input  logic                          Rst_n,
  input  logic [DATA_BITS-1:0]          in_data,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic [NUM_OUT*DATA_BITS-1:0]  out_data,
  output logic [NUM_OUT-1:0]            out_valid,
  input  logic [NUM_OUT-1:0]            out_ready,
  output logic [NUM_OUT-1:0]            out_almost_full,
  output logic [31:0]                   stats_in,
  output logic [31:0]                   stats_out,
  output logic [31:0]                   stats_drop
);

  localparam int DEST_W = $clog2(NUM_OUT);
  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = PTR_W + 1;

  logic [DEST_W-1:0]  dest;
  logic [31:0]        dest_ext;
  logic               dest_oor;
  logic [NUM_OUT-1:0] full;
  logic [NUM_OUT-1:0] push;
  logic [NUM_OUT-1:0] pop;
  logic               sel_full;

  assign dest     = in_data[DEST_LSB +: DEST_W];
  assign dest_ext = 32'(dest);
  assign dest_oor = (dest_ext >= 32'(NUM_OUT));

  // Fullness of the addressed channel; an out-of-range dest selects nothing.
  always_comb begin
    sel_full = 1'b0;
    for (int i = 0; i < NUM_OUT; i++) begin
      if (dest_ext == 32'(i)) sel_full = full[i];
    end
  end

  // Ready depends only on in_data and registered counts, never on out_ready.
  assign in_ready = Rst_n & (dest_oor | ~sel_full);

  for (genvar g = 0; g < NUM_OUT; g++) begin : g_ch
    logic [DATA_BITS-1:0] mem [DEPTH];
    logic [PTR_W-1:0]     rd;
    logic [PTR_W-1:0]     wr;
    logic [CNT_W-1:0]     count;

    assign full[g]            = (count == CNT_W'(DEPTH));
    assign push[g]            = in_valid & in_ready & (dest_ext == 32'(g));
    assign pop[g]             = out_valid[g] & out_ready[g];
    assign out_valid[g]       = (count != '0);
    assign out_almost_full[g] = (count >= CNT_W'(AF_THRESH));
    assign out_data[g*DATA_BITS +: DATA_BITS] = mem[rd];

    // Pointer and occupancy tracking; a push and pop together leave count unchanged.
    always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
        rd    <= '0;
        wr    <= '0;
        count <= '0;
      end else begin
        if (push[g]) wr <= wr + PTR_W'(1);
        if (pop[g])  rd <= rd + PTR_W'(1);
        case ({push[g], pop[g]})
          2'b10:   count <= count + CNT_W'(1);
          2'b01:   count <= count - CNT_W'(1);
          default: count <= count;
        endcase
      end
    end

    // Storage is not reset; contents are abandoned on reset.
    always_ff @(posedge Clk) begin
      if (push[g]) mem[wr] <= in_data;
    end
  end

`ifdef META_ROUTE_FANOUT_STATS_EN
  logic [NUM_OUT-1:0][31:0] pop_cnt;
  logic [31:0]              pop_sum;
  logic                     accepted;
  logic [31:0]              cnt_in;
  logic [31:0]              cnt_drop;
  logic [31:0]              cnt_out;

  assign accepted = in_valid & in_ready;

  for (genvar g = 0; g < NUM_OUT; g++) begin : g_pop
    // Per-channel pop counter, wraps silently.
    always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n)      pop_cnt[g] <= '0;
      else if (pop[g]) pop_cnt[g] <= pop_cnt[g] + 32'd1;
    end
  end

  // Modulo-2^32 sum of the per-channel pop counters.
  always_comb begin
    pop_sum = '0;
    for (int i = 0; i < NUM_OUT; i++) pop_sum = pop_sum + pop_cnt[i];
  end

  // Aggregate counters; stats_out lags the pop counters by one cycle.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      cnt_in   <= '0;
      cnt_drop <= '0;
      cnt_out  <= '0;
    end else begin
      if (accepted)            cnt_in   <= cnt_in + 32'd1;
      if (accepted & dest_oor) cnt_drop <= cnt_drop + 32'd1;
      cnt_out <= pop_sum;
    end
  end

  assign stats_in   = cnt_in;
  assign stats_out  = cnt_out;
  assign stats_drop = cnt_drop;
`else
  assign stats_in   = '0;
  assign stats_out  = '0;
  assign stats_drop = '0;
`endif

endmodule
